// File: rtl/captura_numero.sv
// ---------------------------------------------------------------------------
// captura_numero
//
// Reader side of the keypad scanner capture handshake. Each accepted key
// (one-hot column/row with pressed_valid) is latched, decoded and
// acknowledged once with a single-cycle ack_read. Digits accumulate into a
// multi-digit entry held both as BCD and as binary. '*' clears the entry
// and '#' commits it to committed_value.
//
// Ports
//   clk              in   single clock, all state on the rising edge
//   rst_n            in   asynchronous active-low reset
//   pressed_col_in   in   one-hot key column (MSB = column 0)
//   pressed_row_in   in   one-hot key row    (MSB = row 0)
//   pressed_valid    in   writer holds high while a key is available
//   ack_read         out  one-cycle acknowledge of the latched key
//   digits           out  BCD entry, newest digit in bits [3:0]
//   digit_count      out  number of digits currently held
//   value            out  binary equivalent of digits
//   committed_value  out  last committed entry
//   commit_valid     out  one-cycle pulse when committed_value updates
//   clear_pulse      out  one-cycle pulse on '*'
//   key_error        out  one-cycle pulse on an unmapped / non-one-hot key
//   overflow         out  one-cycle pulse on a digit while the entry is full
// ---------------------------------------------------------------------------
module captura_numero #(
    parameter int WIDTH      = 4,
    parameter int MAX_DIGITS = 4,
    parameter int VALUE_W    = 14
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WIDTH-1:0]                  pressed_col_in,
    input  logic [WIDTH-1:0]                  pressed_row_in,
    input  logic                              pressed_valid,
    output logic                              ack_read,
    output logic [4*MAX_DIGITS-1:0]           digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic [VALUE_W-1:0]                value,
    output logic [VALUE_W-1:0]                committed_value,
    output logic                              commit_valid,
    output logic                              clear_pulse,
    output logic                              key_error,
    output logic                              overflow
);

    localparam int CNT_W = $clog2(MAX_DIGITS+1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DECODE    = 2'd1;
    localparam logic [1:0] ACK       = 2'd2;
    localparam logic [1:0] WAIT_DROP = 2'd3;

    logic [1:0]              r_state;
    logic [WIDTH-1:0]        r_col;
    logic [WIDTH-1:0]        r_row;
    logic [4*MAX_DIGITS-1:0] r_digits;
    logic [CNT_W-1:0]        r_count;
    logic [VALUE_W-1:0]      r_value;
    logic [VALUE_W-1:0]      r_committed;
    logic                    r_commit_valid;
    logic                    r_clear_pulse;
    logic                    r_key_error;
    logic                    r_overflow;

    int                      w_col_idx;
    int                      w_row_idx;
    logic                    w_code_ok;
    logic                    w_is_digit;
    logic                    w_is_star;
    logic                    w_is_hash;
    logic [3:0]              w_digit;
    logic                    w_full;
    logic [VALUE_W+3:0]      w_value_next;

    // Decode the latched key. Column/row index 0 is the MSB of the one-hot
    // code. Rows 0..2 carry digits 1..9; row 3 carries '*', 0 and '#'.
    // The last column (index 3) has no keys mapped and is an error.
    always_comb begin
        w_col_idx  = 0;
        w_row_idx  = 0;
        w_is_digit = 1'b0;
        w_is_star  = 1'b0;
        w_is_hash  = 1'b0;
        w_digit    = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_col[WIDTH-1-i]) w_col_idx = i;
            if (r_row[WIDTH-1-i]) w_row_idx = i;
        end
        w_code_ok = $onehot(r_col) && $onehot(r_row);
        if (w_code_ok && (w_col_idx < 3)) begin
            if (w_row_idx < 3) begin
                w_is_digit = 1'b1;
                w_digit    = 4'(w_row_idx * 3 + w_col_idx + 1);
            end else if (w_row_idx == 3) begin
                case (w_col_idx)
                    0:       w_is_star  = 1'b1;
                    1:       w_is_digit = 1'b1;
                    default: w_is_hash  = 1'b1;
                endcase
            end
        end
    end

    assign w_full = (r_count == CNT_W'(MAX_DIGITS));

    // Widened so the multiply-add cannot wrap before truncation.
    assign w_value_next = ({4'd0, r_value} * (VALUE_W+4)'(10))
                          + (VALUE_W+4)'(w_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_digits       <= '0;
            r_count        <= '0;
            r_value        <= '0;
            r_committed    <= '0;
            r_commit_valid <= 1'b0;
            r_clear_pulse  <= 1'b0;
            r_key_error    <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            // Pulses are only ever raised in DECODE, so they last one cycle.
            r_commit_valid <= 1'b0;
            r_clear_pulse  <= 1'b0;
            r_key_error    <= 1'b0;
            r_overflow     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pressed_valid) begin
                        r_col   <= pressed_col_in;
                        r_row   <= pressed_row_in;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_state <= ACK;
                    if (w_is_digit) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_digits <= {r_digits[4*MAX_DIGITS-5:0], w_digit};
                            r_value  <= w_value_next[VALUE_W-1:0];
                            r_count  <= r_count + CNT_W'(1);
                        end
                    end else if (w_is_star) begin
                        r_digits      <= '0;
                        r_value       <= '0;
                        r_count       <= '0;
                        r_clear_pulse <= 1'b1;
                    end else if (w_is_hash) begin
                        // An empty entry is silently ignored on '#'.
                        if (r_count != '0) begin
                            r_committed    <= r_value;
                            r_commit_valid <= 1'b1;
                            r_digits       <= '0;
                            r_value        <= '0;
                            r_count        <= '0;
                        end
                    end else begin
                        r_key_error <= 1'b1;
                    end
                end
                ACK: begin
                    r_state <= WAIT_DROP;
                end
                default: begin
                    // Hold until the writer releases the key so it is
                    // consumed exactly once.
                    if (!pressed_valid) r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_read        = (r_state == ACK);
    assign digits          = r_digits;
    assign digit_count     = r_count;
    assign value           = r_value;
    assign committed_value = r_committed;
    assign commit_valid    = r_commit_valid;
    assign clear_pulse     = r_clear_pulse;
    assign key_error       = r_key_error;
    assign overflow        = r_overflow;

endmodule

// File: doc/captura_numero.md
# captura_numero

Keypad number-entry consumer. It is the reader side of the keypad scanner's capture handshake: it takes each accepted key (one-hot column/row plus `pressed_valid`) and acknowledges it with `ack_read`. Digits are accumulated into a multi-digit entry kept in both BCD and binary. `*` clears the entry and `#` commits it. Sits between the keypad scanner and the application logic that consumes entered values.

## Interface
- `WIDTH`, 4, keypad column/row count; one-hot widths of the key inputs.
- `MAX_DIGITS`, 4, maximum digits held in one entry.
- `VALUE_W`, 14, binary value width; must hold 10^MAX_DIGITS − 1.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pressed_col_in`  in  WIDTH  one-hot column of the captured key; MSB = column 0.
- `pressed_row_in`  in  WIDTH  one-hot row of the captured key; MSB = row 0.
- `pressed_valid`  in  1  writer holds high while a key is available.
- `ack_read`  out  1  one-cycle acknowledge; writer clears `pressed_valid` on the following edge.
- `digits`  out  4*MAX_DIGITS  BCD entry; newest digit in bits [3:0].
- `digit_count`  out  $clog2(MAX_DIGITS+1)  digits currently held.
- `value`  out  VALUE_W  binary equivalent of `digits`.
- `committed_value`  out  VALUE_W  last committed entry; holds until the next commit.
- `commit_valid`  out  1  one-cycle pulse when `committed_value` updates.
- `clear_pulse`  out  1  one-cycle pulse on `*`.
- `key_error`  out  1  one-cycle pulse on an unmapped or non-one-hot key.
- `overflow`  out  1  one-cycle pulse on a digit while `digit_count == MAX_DIGITS`.

## Operation
- FSM states: `IDLE`, `DECODE`, `ACK`, `WAIT_DROP`.
  - `IDLE`: when `pressed_valid` is 1, latch `pressed_col_in`/`pressed_row_in` into internal registers and go to `DECODE`. Otherwise stay.
  - `DECODE`: act on the latched key (see below), then go to `ACK`.
  - `ACK`: `ack_read` = 1 (decoded from the state register); go to `WAIT_DROP` unconditionally.
  - `WAIT_DROP`: stay until `pressed_valid` = 0, then go to `IDLE`. This guarantees each key is consumed exactly once.
- Key map, written as {col, row}:
  - Row 1000: col 1000 = 1, col 0100 = 2, col 0010 = 3.
  - Row 0100: 4, 5, 6 (same column order).
  - Row 0010: 7, 8, 9.
  - Row 0001: col 1000 = `*`, col 0100 = 0, col 0010 = `#`.
  - Column 0001, and any zero or multi-hot code, are errors: pulse `key_error`; accumulator unchanged.
- Digit d with `digit_count < MAX_DIGITS`:
  - `digits <= {digits[4*MAX_DIGITS-5:0], d}`
  - `value <= value*10 + d`
  - `digit_count` + 1
  - Leading zeros count as digits.
- Digit d when full: pulse `overflow`; nothing else changes.
- `*`: `digits`, `value` and `digit_count` go to 0; pulse `clear_pulse`.
- `#` with `digit_count > 0`:
  - `committed_value <= value`; pulse `commit_valid`.
  - Clear the accumulator in the same edge.
- `#` with `digit_count == 0`: no commit, no pulse, no error.
- Arithmetic is unsigned; `value*10 + d` is computed at VALUE_W+4 bits and truncated to VALUE_W. The `VALUE_W` rule guarantees no loss.

## Timing
- Reset (async assert, sync release):
  - State goes to `IDLE`.
  - All outputs are 0: `ack_read`, `digits`, `digit_count`, `value`, `committed_value`, and all pulses.
  - Reset mid-handshake aborts the transaction. If `pressed_valid` is still high after release, that key is consumed as new.
- Per-key schedule, where E0 is the edge at which `IDLE` samples `pressed_valid` = 1:
  - E0: key latched.
  - E1: accumulator and pulse outputs update. Pulses are high for exactly the cycle E1–E2.
  - `ack_read` is high for exactly the cycle E1–E2.
  - E3: earliest return to `IDLE` (the writer drops `pressed_valid` at E2).
  - E4: earliest capture of the next key.
- If `pressed_valid` stays high past E3, the FSM holds in `WAIT_DROP` and `ack_read` is not re-asserted.
- Changes on `pressed_col_in`/`pressed_row_in` after E0 are ignored.
- At most one pulse output is high in any cycle.

## Test plan
- Reset, then keys 1, 2, 3, `#` (each with a full handshake) -> `digits` = 0x0123 before `#`; after `#`, `committed_value` = 123, `commit_valid` high for 1 cycle, `digit_count` = 0.
- Keys 9, 9, 9, 9, 5 with `MAX_DIGITS` = 4 -> `value` = 9999; fifth key pulses `overflow`; `value` stays 9999.
- Keys 4, 5, `*`, 0, 7, `#` -> `clear_pulse` after `*`; `committed_value` = 7; `digit_count` stepped 1→2 for 0 and 7.
- Key col 0001 / row 1000, then col 1100 / row 1000 -> two `key_error` pulses; accumulator unchanged; each still gets exactly one `ack_read`.
- `pressed_valid` held high for 10 cycles -> exactly one `ack_read` and one digit accepted; `IDLE` re-entered one edge after the drop.
- `rst_n` asserted in the `ACK` state after keys 3, 3 -> all outputs 0 immediately; next key 8 gives `value` = 8.
